// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scanner with a double-buffered frame:
// loads land in a shadow buffer and are applied only at frame end or while off.
module seg_scan_ctrl #(
  parameter int DIV   = 100000,
  parameter int BLANK = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  blank_in,
  input  logic [7:0]  dp_in,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        pending,
  output logic        frame_done
);

  // state   | meaning
  // S_OFF   | display dark, slot counter and digit index parked at 0
  // S_BLANK | first BLANK cycles of a slot, all anodes off
  // S_DRIVE | remaining DIV-BLANK cycles of a slot, digit idx lit
  typedef enum logic [1:0] {S_OFF, S_BLANK, S_DRIVE} state_t;

  localparam int            CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_DRIVE = CW'(BLANK);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;

  logic [31:0]   sh_data_q, act_data_q;
  logic [7:0]    sh_blank_q, act_blank_q;
  logic [7:0]    sh_dp_q, act_dp_q;
  logic          pending_q, pending_d;
  logic          frame_done_q;
  logic          transfer;

  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!enable) begin
      state_d = S_OFF;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == S_OFF) begin
      state_d = S_BLANK;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (cnt_q == CNT_LAST) begin
      state_d = S_BLANK;
      cnt_d   = '0;
      idx_d   = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_d == CNT_DRIVE) state_d = S_DRIVE;
    end
  end

  // Shadow is applied only when nothing is lit: while off, or at the last
  // cycle of digit 7 so the next frame starts with a blank phase.
  always_comb begin
    transfer = pending_q &&
               ((state_q == S_OFF) ||
                (state_q == S_DRIVE && idx_q == 3'd7 && cnt_q == CNT_LAST));
    if (load)          pending_d = 1'b1;
    else if (transfer) pending_d = 1'b0;
    else               pending_d = pending_q;
  end

  // Outputs are derived from the next state so they register in step with it.
  always_comb begin
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (state_d == S_DRIVE) begin
      seg_d = hex_to_seg(act_data_q[{idx_d, 2'b00} +: 4]);
      dp_d  = ~act_dp_q[idx_d];
      if (!act_blank_q[idx_d]) an_d = ~(8'b1 << idx_d);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_OFF;
      cnt_q        <= '0;
      idx_q        <= '0;
      sh_data_q    <= '0;
      sh_blank_q   <= '0;
      sh_dp_q      <= '0;
      act_data_q   <= '0;
      act_blank_q  <= '0;
      act_dp_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      frame_done_q <= transfer;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      if (transfer) begin
        act_data_q  <= sh_data_q;
        act_blank_q <= sh_blank_q;
        act_dp_q    <= sh_dp_q;
      end
      if (load) begin
        sh_data_q  <= data_in;
        sh_blank_q <= blank_in;
        sh_dp_q    <= dp_in;
      end
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a time-indexed scan model (cycles since enable)
// is compared every cycle, plus directed scenarios with literal expectations.
module tb_seg_scan_ctrl;
  localparam int DIV   = 8;
  localparam int BLANK = 2;

  logic        clk = 1'b0;
  logic        reset, enable, load;
  logic [31:0] data_in;
  logic [7:0]  blank_in, dp_in;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp, pending, frame_done;

  int errors = 0;
  int checks = 0;

  seg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .data_in(data_in), .blank_in(blank_in), .dp_in(dp_in),
    .an(an), .seg(seg), .dp(dp), .pending(pending), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Active-high segment patterns {g,f,e,d,c,b,a} for hex 0..F.
  logic [6:0] seg_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: m_t counts cycles since scanning started; slot, digit and phase
  // follow by division.
  bit          m_on = 0, m_pend = 0, m_fd = 0, m_xfer = 0;
  int          m_t = 0;
  logic [31:0] m_act_d = '0, m_sh_d = '0;
  logic [7:0]  m_act_b = '0, m_sh_b = '0, m_act_p = '0, m_sh_p = '0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_on = 0; m_t = 0; m_pend = 0; m_fd = 0;
      m_act_d = '0; m_sh_d = '0; m_act_b = '0; m_sh_b = '0; m_act_p = '0; m_sh_p = '0;
    end else begin
      m_xfer = m_pend && (!m_on || ((m_t % DIV == DIV - 1) && ((m_t / DIV) % 8 == 7)));
      if (m_xfer) begin
        m_act_d = m_sh_d; m_act_b = m_sh_b; m_act_p = m_sh_p;
      end
      m_fd = m_xfer;
      if (load) begin
        m_sh_d = data_in; m_sh_b = blank_in; m_sh_p = dp_in; m_pend = 1;
      end else if (m_xfer) begin
        m_pend = 0;
      end
      if (!enable) begin m_on = 0; m_t = 0; end
      else if (!m_on) begin m_on = 1; m_t = 0; end
      else m_t = m_t + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    int          dig;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    @(negedge clk);
    dig   = (m_t / DIV) % 8;
    e_an  = 8'hFF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (m_on && (m_t % DIV) >= BLANK) begin
      e_seg = ~seg_hi[m_act_d[dig*4 +: 4]];
      e_dp  = ~m_act_p[dig];
      if (!m_act_b[dig]) e_an = ~(8'd1 << dig);
    end
    chk("model_an", 32'(an), 32'(e_an));
    chk("model_seg", 32'(seg), 32'(e_seg));
    chk("model_dp", 32'(dp), 32'(e_dp));
    chk("model_pending", 32'(pending), 32'(m_pend));
    chk("model_frame_done", 32'(frame_done), 32'(m_fd));
  end

  function automatic bit at(input int d, input int c);
    return m_on && ((m_t / DIV) % 8 == d) && (m_t % DIV == c);
  endfunction

  task automatic wait_at(input int d, input int c);
    int n = 0;
    while (!at(d, c) && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (!at(d, c)) begin
      errors++;
      $display("FAIL wait_at: digit %0d cnt %0d not reached, got timeout", d, c);
    end
  endtask

  task automatic wait_fd(input string name);
    int n = 0;
    while (frame_done !== 1'b1 && n < 150) begin @(negedge clk); n++; end
    chk(name, 32'(frame_done), 32'h1);
  endtask

  task automatic drive_load(input logic [31:0] d, input logic [7:0] b, input logic [7:0] p);
    load = 1'b1; data_in = d; blank_in = b; dp_in = p;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int lit, fd_cnt, bad, good, dp0;
    reset = 1'b1; enable = 1'b0; load = 1'b0;
    data_in = '0; blank_in = '0; dp_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Load while off: applied on the following cycle.
    drive_load(32'h76543210, 8'h00, 8'h00);
    chk("off_pending", 32'(pending), 32'h1);
    chk("off_fd_early", 32'(frame_done), 32'h0);
    @(negedge clk);
    chk("off_fd", 32'(frame_done), 32'h1);
    chk("off_pending_clr", 32'(pending), 32'h0);

    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("d0_an", 32'(an), 32'hFE);
    chk("d0_seg", 32'(seg), 32'h40);
    lit = 0;
    for (int i = 0; i < 64; i++) begin
      if (an !== 8'hFF) lit++;
      @(negedge clk);
    end
    chk("lit_cycles", 32'(lit), 32'd48);
    wait_at(3, 2);
    chk("d3_an", 32'(an), 32'hF7);
    chk("d3_seg", 32'(seg), 32'h30);

    // Deferred update.
    wait_at(3, 4);
    drive_load(32'hFFFFFFFF, 8'h00, 8'h00);
    chk("defer_pending", 32'(pending), 32'h1);
    wait_at(5, 3);
    chk("defer_old_seg", 32'(seg), 32'h12);
    wait_fd("defer_fd");
    repeat (2) @(negedge clk);
    chk("defer_new_an", 32'(an), 32'hFE);
    chk("defer_new_seg", 32'(seg), 32'h0E);

    // Back-to-back loads.
    wait_at(0, 0);
    drive_load(32'h11111111, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    drive_load(32'h22222222, 8'h00, 8'h00);
    fd_cnt = 0; bad = 0; good = 0;
    for (int i = 0; i < 140; i++) begin
      if (frame_done === 1'b1) fd_cnt++;
      if (an !== 8'hFF && seg === 7'h79) bad++;
      if (an !== 8'hFF && seg === 7'h24) good++;
      @(negedge clk);
    end
    chk("b2b_fd_count", 32'(fd_cnt), 32'd1);
    chk("b2b_a_never_shown", 32'(bad), 32'd0);
    chk("b2b_b_shown", 32'(good > 0), 32'h1);

    // Load coinciding with the transfer cycle.
    wait_at(2, 2);
    drive_load(32'h01234567, 8'h00, 8'h00);
    wait_at(7, 7);
    drive_load(32'h89ABCDEF, 8'h81, 8'h02);
    chk("coinc_fd", 32'(frame_done), 32'h1);
    chk("coinc_pending", 32'(pending), 32'h1);

    // Blank mask and decimal point.
    @(negedge clk);
    wait_fd("blank_fd");
    bad = 0; dp0 = 0;
    for (int i = 0; i < 64; i++) begin
      if (an[0] === 1'b0 || an[7] === 1'b0) bad++;
      if (dp === 1'b0) begin
        dp0++;
        if (an !== 8'hFD) bad++;
      end
      @(negedge clk);
    end
    chk("blank_d0_d7_dark", 32'(bad), 32'd0);
    chk("dp_cycles", 32'(dp0), 32'd6);

    // Enable drop during digit 5.
    drive_load(32'h13579BDF, 8'h00, 8'h00);
    wait_fd("drop_prep_fd");
    wait_at(5, 4);
    enable = 1'b0;
    @(negedge clk);
    chk("drop_an", 32'(an), 32'hFF);
    chk("drop_seg", 32'(seg), 32'h7F);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("reen_blank_an", 32'(an), 32'hFF);
    repeat (2) @(negedge clk);
    chk("reen_d0_an", 32'(an), 32'hFE);
    chk("reen_d0_seg", 32'(seg), 32'h0E);

    // Sub-cycle asynchronous reset while a digit is lit.
    wait_at(2, 4);
    drive_load(32'hDEADBEEF, 8'h00, 8'hFF);
    #2 reset = 1'b1;
    #1;
    chk("arst_an", 32'(an), 32'hFF);
    chk("arst_seg", 32'(seg), 32'h7F);
    chk("arst_dp", 32'(dp), 32'h1);
    chk("arst_pending", 32'(pending), 32'h0);
    #1 reset = 1'b0;
    wait_at(0, 2);
    chk("arst_restart_an", 32'(an), 32'hFE);
    chk("arst_restart_seg", 32'(seg), 32'h40);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      load     = ($urandom_range(0, 19) == 0);
      data_in  = $urandom;
      blank_in = 8'($urandom);
      dp_in    = 8'($urandom);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      @(negedge clk);
    end
    load = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
